// File: rtl/legv8_enc_pkg.sv
// legv8_enc_pkg: shared kinds, error codes, opcodes and encoder states
package legv8_enc_pkg;
  typedef enum logic [1:0] {LDUR, STUR, CBZ, ILLEGAL} kind_t;
  typedef enum logic [1:0] {NONE, KIND, RANGE, ALIGN} err_t;
  typedef enum logic [1:0] {RUN, FULL, ERROR} state_t;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational LEGv8 field packer and immediate legality check
// kind/rt/rn/imm in; word = encoded instruction, err = first failing check (KIND > ALIGN > RANGE)
module instr_pack
  import legv8_enc_pkg::*;
(
  input  kind_t       kind,
  input  logic [4:0]  rt,
  input  logic [4:0]  rn,
  input  logic [63:0] imm,
  output logic [31:0] word,
  output err_t        err
);
  logic mem_ok, br_ok;
  always_comb begin
    mem_ok = imm[63:8] == {56{imm[8]}};
    br_ok  = imm[63:20] == {44{imm[20]}};
    err    = kind == ILLEGAL ? KIND :
             kind == CBZ     ? (imm[1:0] != 2'b00 ? ALIGN : br_ok ? NONE : RANGE) :
             mem_ok          ? NONE : RANGE;
    word   = kind == LDUR ? {OP_LDUR, imm[8:0], 2'b00, rn, rt} :
             kind == STUR ? {OP_STUR, imm[8:0], 2'b00, rn, rt} :
             kind == CBZ  ? {OP_CBZ, imm[20:2], rt} : 32'h0;
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming LDUR/STUR/CBZ encoder writing sequential imem words
// in_* request handshake, wr_* imem write handshake, count = committed words, err/err_code sticky
module instr_encoder
  import legv8_enc_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rn,
  input  logic [63:0]       in_imm,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic [1:0]        err_code
);
  logic [1:0]        rst_sync_q, rst_sync_d;
  logic              rst_ni;
  state_t            state_q, state_d;
  logic [ADDR_W:0]   alloc_q, alloc_d, alloc_inc;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              err_q, err_d;
  err_t              err_code_q, err_code_d;
  logic [31:0]       pk_word;
  err_t              pk_err;
  logic              commit, accept, good, bad;

  instr_pack u_pack (
    .kind (kind_t'(in_kind)),
    .rt   (in_rt),
    .rn   (in_rn),
    .imm  (in_imm),
    .word (pk_word),
    .err  (pk_err)
  );

  // reset asserts asynchronously but releases on a clock edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;

  // alloc/count are ADDR_W+1 wide and never exceed DEPTH, so the MSB means "at DEPTH"
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
    rst_ni     = rst_sync_q[1];
    commit     = wr_en_q && wr_ready;
    in_ready   = rst_ni && state_q == RUN && (!wr_en_q || wr_ready) && !alloc_q[ADDR_W];
    accept     = in_valid && in_ready;
    good       = accept && pk_err == NONE;
    bad        = accept && pk_err != NONE;
    alloc_inc  = alloc_q + 1'b1;
    state_d    = clear ? RUN : bad ? ERROR : good && alloc_inc[ADDR_W] ? FULL : state_q;
    alloc_d    = clear ? '0 : good ? alloc_inc : alloc_q;
    count_d    = clear ? '0 : commit && !count_q[ADDR_W] ? count_q + 1'b1 : count_q;
    wr_en_d    = !clear && (good || (wr_en_q && !wr_ready));
    wr_addr_d  = clear ? '0 : good ? alloc_q[ADDR_W-1:0] : wr_addr_q;
    wr_data_d  = clear ? '0 : good ? pk_word : wr_data_q;
    err_d      = !clear && (err_q || bad);
    err_code_d = clear ? NONE : bad ? pk_err : err_code_q;
  end

  always_ff @(posedge clk or negedge rst_ni)
    if (!rst_ni) begin
      state_q    <= RUN;
      alloc_q    <= '0;
      count_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= NONE;
    end else begin
      state_q    <= state_d;
      alloc_q    <= alloc_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign count    = count_q;
  assign err      = err_q;
  assign err_code = err_code_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized self-checking bench for instr_encoder against an arithmetic model
module tb_instr_encoder;
  logic clk = 1'b0;
  logic reset, clear, in_valid, in_ready, wr_en, wr_ready, err;
  logic [1:0] in_kind, err_code;
  logic [4:0] in_rt, in_rn;
  logic [63:0] in_imm;
  logic [5:0] wr_addr;
  logic [31:0] wr_data;
  logic [6:0] count;
  logic s_clear, s_valid, s_ready, s_wr_en, s_wr_ready, s_err;
  logic [1:0] s_kind, s_err_code;
  logic [4:0] s_rt, s_rn;
  logic [63:0] s_imm;
  logic [1:0] s_addr;
  logic [31:0] s_data;
  logic [2:0] s_count;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_encoder u_dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rt(in_rt), .in_rn(in_rn), .in_imm(in_imm), .wr_en(wr_en),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .count(count), .err(err),
    .err_code(err_code)
  );

  instr_encoder #(.ADDR_W(2)) u_small (
    .clk(clk), .reset(reset), .clear(s_clear), .in_valid(s_valid), .in_ready(s_ready),
    .in_kind(s_kind), .in_rt(s_rt), .in_rn(s_rn), .in_imm(s_imm), .wr_en(s_wr_en),
    .wr_ready(s_wr_ready), .wr_addr(s_addr), .wr_data(s_data), .count(s_count), .err(s_err),
    .err_code(s_err_code)
  );

  // {err_code, word} from the encoding rules, using signed arithmetic on the immediate
  function automatic logic [33:0] ref_enc(input int kind, input int rt, input int rn, input longint imm);
    longint w;
    int e;
    e = 0;
    w = 0;
    if (kind == 3) e = 1;
    else if (kind == 2) begin
      if (imm % 4 != 0) e = 3;
      else if (imm < -(64'sd1 << 20) || imm >= (64'sd1 << 20)) e = 2;
      w = (64'hB4 << 24) | (((imm / 4) & 64'h7FFFF) << 5) | longint'(rt);
    end else begin
      if (imm < -256 || imm > 255) e = 2;
      w = ((kind == 0 ? 64'h7C2 : 64'h7C0) << 21) | ((imm & 64'h1FF) << 12) | (longint'(rn) << 5) | longint'(rt);
    end
    return {e[1:0], w[31:0]};
  endfunction

  // decode-side immediate extraction, used to confirm the round trip
  function automatic longint ext_imm(input int kind, input logic [31:0] w);
    longint v;
    if (kind == 2) begin
      v = longint'((w >> 5) & 32'h7FFFF);
      if (v >= 262144) v -= 524288;
      return v * 4;
    end
    v = longint'((w >> 12) & 32'h1FF);
    if (v >= 256) v -= 512;
    return v;
  endfunction

  function automatic longint rnd_legal(input int kind);
    int s, t;
    s = $urandom_range(0, 7);
    if (kind == 2) begin
      t = $urandom_range(0, 524287);
      return s == 0 ? -64'sd1048576 : s == 1 ? 64'sd1048572 : longint'(t - 262144) * 4;
    end
    t = $urandom_range(0, 511);
    return s == 0 ? -64'sd256 : s == 1 ? 64'sd255 : longint'(t - 256);
  endfunction

  function automatic longint rnd_any();
    int s, t;
    s = $urandom_range(0, 3);
    t = $urandom_range(0, 4194303);
    if (s == 0) return longint'(t % 600 - 300);
    if (s == 2) return {$urandom, $urandom};
    if (s == 3) return longint'(t - 2097152);
    case (t % 10)
      0: return -257;
      1: return -256;
      2: return 255;
      3: return 256;
      4: return -1048576;
      5: return 1048572;
      6: return 1048576;
      7: return -1048580;
      8: return 6;
      default: return -2;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int k, input int rt, input int rn, input longint imm);
    in_valid = 1'b1;
    in_kind = 2'(k);
    in_rt = 5'(rt);
    in_rn = 5'(rn);
    in_imm = imm;
  endtask

  task automatic do_clear();
    cyc();
    clear = 1'b1;
    in_valid = 1'b0;
    cyc();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; wr_ready = 1'b1;
    s_clear = 1'b0; s_valid = 1'b0; s_wr_ready = 1'b1; s_kind = 2'd0; s_rt = 5'd0; s_rn = 5'd0; s_imm = '0;
    req(0, 1, 2, 16);
    repeat (3) cyc();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0h exp=0", in_ready); end
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%0h exp=0", wr_en); end
    checks++; if (wr_addr !== 6'd0 || wr_data !== 32'd0) begin failures++; $display("FAIL reset_out got=%0h/%0h exp=0/0", wr_addr, wr_data); end
    checks++; if (count !== 7'd0 || err !== 1'b0 || err_code !== 2'd0) begin failures++; $display("FAIL reset_status got=%0d/%0h/%0h exp=0/0/0", count, err, err_code); end
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (4) cyc();
    checks++; if (in_ready !== 1'b1 || wr_en !== 1'b0) begin failures++; $display("FAIL reset_release got=%0h/%0h exp=1/0", in_ready, wr_en); end
  endtask

  task automatic test_ldur();
    do_clear();
    wr_ready = 1'b1;
    req(0, 1, 2, 16);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ldur_ready got=%0h exp=1", in_ready); end
    cyc();
    in_valid = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd0) begin failures++; $display("FAIL ldur_wr got=%0h@%0h exp=1@0", wr_en, wr_addr); end
    checks++; if (wr_data !== 32'hF8410041) begin failures++; $display("FAIL ldur_data got=%08h exp=f8410041", wr_data); end
    cyc();
    checks++; if (count !== 7'd1 || wr_en !== 1'b0) begin failures++; $display("FAIL ldur_count got=%0d/%0h exp=1/0", count, wr_en); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    wr_ready = 1'b1;
    req(1, 3, 4, -8);
    cyc();
    req(2, 5, 0, -4);
    #1;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== 32'hF81F8083) begin failures++; $display("FAIL b2b_first got=%0h@%0h:%08h exp=1@0:f81f8083", wr_en, wr_addr, wr_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%0h exp=1", in_ready); end
    cyc();
    in_valid = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd1 || wr_data !== 32'hB4FFFFE5) begin failures++; $display("FAIL b2b_second got=%0h@%0h:%08h exp=1@1:b4ffffe5", wr_en, wr_addr, wr_data); end
    cyc();
    checks++; if (count !== 7'd2 || wr_en !== 1'b0) begin failures++; $display("FAIL b2b_count got=%0d/%0h exp=2/0", count, wr_en); end
  endtask

  task automatic test_errors();
    do_clear();
    wr_ready = 1'b1;
    req(0, 1, 2, 256);
    cyc();
    in_valid = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || err !== 1'b1 || err_code !== 2'd2 || in_ready !== 1'b0) begin failures++; $display("FAIL err_range got=%0h/%0h/%0h/%0h exp=0/1/2/0", wr_en, err, err_code, in_ready); end
    do_clear();
    #1;
    checks++; if (err !== 1'b0 || err_code !== 2'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL err_clear got=%0h/%0h/%0h exp=0/0/1", err, err_code, in_ready); end
    req(2, 1, 0, 6);
    cyc();
    in_valid = 1'b0;
    #1;
    checks++; if (err_code !== 2'd3 || wr_en !== 1'b0) begin failures++; $display("FAIL err_align got=%0h/%0h exp=3/0", err_code, wr_en); end
    do_clear();
    req(3, 1, 2, 0);
    cyc();
    req(0, 1, 2, 0);
    cyc();
    cyc();
    checks++; if (err !== 1'b1 || err_code !== 2'd1 || wr_en !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL err_kind_hold got=%0h/%0h/%0h/%0h exp=1/1/0/0", err, err_code, wr_en, in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [33:0] r;
    longint imm;
    do_clear();
    imm = rnd_legal(1);
    r = ref_enc(1, 9, 10, imm);
    wr_ready = 1'b0;
    req(1, 9, 10, imm);
    cyc();
    req(0, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== r[31:0] || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold%0d got=%0h@%0h:%08h rdy=%0h exp=1@0:%08h rdy=0", i, wr_en, wr_addr, wr_data, in_ready, r[31:0]); end
      cyc();
    end
    wr_ready = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || count !== 7'd0) begin failures++; $display("FAIL bp_release got=%0h/%0d exp=1/0", in_ready, count); end
    cyc();
    checks++; if (count !== 7'd1 || wr_en !== 1'b0) begin failures++; $display("FAIL bp_commit got=%0d/%0h exp=1/0", count, wr_en); end
    req(0, 2, 3, 4);
    cyc();
    clear = 1'b1;
    #1;
    cyc();
    clear = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || count !== 7'd0) begin failures++; $display("FAIL clear_priority got=%0h/%0d exp=0/0", wr_en, count); end
  endtask

  task automatic test_full();
    logic [31:0] exp_w[4];
    logic [33:0] r;
    int k;
    longint imm;
    for (int i = 0; i < 4; i++) begin
      k = $urandom_range(0, 2);
      imm = rnd_legal(k);
      r = ref_enc(k, i + 1, i + 2, imm);
      exp_w[i] = r[31:0];
      s_valid = 1'b1; s_kind = 2'(k); s_rt = 5'(i + 1); s_rn = 5'(i + 2); s_imm = imm;
      #1;
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL full_ready%0d got=%0h exp=1", i, s_ready); end
      if (i > 0) begin
        checks++; if (s_wr_en !== 1'b1 || s_addr !== 2'(i - 1) || s_data !== exp_w[i-1]) begin failures++; $display("FAIL full_word%0d got=%0h@%0h:%08h exp=1@%0d:%08h", i - 1, s_wr_en, s_addr, s_data, i - 1, exp_w[i-1]); end
      end
      cyc();
    end
    s_imm = '0;
    #1;
    checks++; if (s_addr !== 2'd3 || s_data !== exp_w[3] || s_ready !== 1'b0 || s_count !== 3'd3) begin failures++; $display("FAIL full_last got=%0h:%08h rdy=%0h cnt=%0d exp=3:%08h rdy=0 cnt=3", s_addr, s_data, s_ready, s_count, exp_w[3]); end
    cyc();
    cyc();
    cyc();
    checks++; if (s_count !== 3'd4 || s_wr_en !== 1'b0 || s_ready !== 1'b0 || s_err !== 1'b0) begin failures++; $display("FAIL full_stop got=%0d/%0h/%0h/%0h exp=4/0/0/0", s_count, s_wr_en, s_ready, s_err); end
    s_clear = 1'b1;
    cyc();
    s_clear = 1'b0;
    s_valid = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b1 || s_count !== 3'd0 || s_err_code !== 2'd0) begin failures++; $display("FAIL full_clear got=%0h/%0d/%0h exp=1/0/0", s_ready, s_count, s_err_code); end
  endtask

  task automatic test_random_stream();
    logic [31:0] qd[$];
    int qa[$], qk[$];
    longint qi[$];
    logic [33:0] r;
    int alloc, committed, k, rt, rn;
    longint imm;
    logic exp_ready;
    do_clear();
    alloc = 0;
    committed = 0;
    for (int n = 0; n < 800 && (alloc < 64 || qd.size() != 0); n++) begin
      k = $urandom_range(0, 2);
      rt = $urandom_range(0, 31);
      rn = $urandom_range(0, 31);
      imm = rnd_legal(k);
      req(k, rt, rn, imm);
      in_valid = $urandom_range(0, 3) != 0;
      wr_ready = $urandom_range(0, 2) != 0;
      #1;
      exp_ready = (qd.size() == 0 || wr_ready) && alloc < 64;
      checks++; if (count !== 7'(committed)) begin failures++; $display("FAIL stream_count got=%0d exp=%0d", count, committed); end
      checks++; if (wr_en !== (qd.size() != 0)) begin failures++; $display("FAIL stream_wr_en got=%0h exp=%0h", wr_en, qd.size() != 0); end
      checks++; if (in_ready !== exp_ready) begin failures++; $display("FAIL stream_ready got=%0h exp=%0h", in_ready, exp_ready); end
      if (qd.size() != 0) begin
        checks++; if (wr_addr !== 6'(qa[0]) || wr_data !== qd[0]) begin failures++; $display("FAIL stream_word got=%0h:%08h exp=%0h:%08h", wr_addr, wr_data, qa[0], qd[0]); end
        checks++; if (ext_imm(qk[0], wr_data) !== qi[0]) begin failures++; $display("FAIL stream_roundtrip got=%0d exp=%0d", ext_imm(qk[0], wr_data), qi[0]); end
        if (wr_ready) begin
          void'(qd.pop_front()); void'(qa.pop_front()); void'(qk.pop_front()); void'(qi.pop_front());
          committed++;
        end
      end
      if (in_valid && exp_ready) begin
        r = ref_enc(k, rt, rn, imm);
        qd.push_back(r[31:0]); qa.push_back(alloc); qk.push_back(k); qi.push_back(imm);
        alloc++;
      end
      cyc();
    end
    checks++; if (alloc != 64 || qd.size() != 0) begin failures++; $display("FAIL stream_timeout got=%0d/%0d exp=64/0", alloc, qd.size()); end
    wr_ready = 1'b1;
    req(0, 1, 1, 1);
    #1;
    checks++; if (count !== 7'd64 || in_ready !== 1'b0 || wr_en !== 1'b0) begin failures++; $display("FAIL stream_full got=%0d/%0h/%0h exp=64/0/0", count, in_ready, wr_en); end
    in_valid = 1'b0;
  endtask

  task automatic test_random_errors();
    logic [33:0] r;
    int k;
    longint imm;
    for (int i = 0; i < 40; i++) begin
      do_clear();
      wr_ready = 1'b1;
      k = $urandom_range(0, 3);
      imm = rnd_any();
      r = ref_enc(k, i % 32, 31 - i % 32, imm);
      req(k, i % 32, 31 - i % 32, imm);
      cyc();
      in_valid = 1'b0;
      #1;
      checks++; if (err !== (r[33:32] != 2'd0) || err_code !== r[33:32]) begin failures++; $display("FAIL rnd_err kind=%0d imm=%0d got=%0h/%0h exp=%0h/%0h", k, imm, err, err_code, r[33:32] != 2'd0, r[33:32]); end
      checks++; if (wr_en !== (r[33:32] == 2'd0) || (r[33:32] == 2'd0 && wr_data !== r[31:0])) begin failures++; $display("FAIL rnd_word kind=%0d imm=%0d got=%0h:%08h exp=%0h:%08h", k, imm, wr_en, wr_data, r[33:32] == 2'd0, r[31:0]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [33:0] r;
    do_clear();
    wr_ready = 1'b0;
    req(0, 3, 3, 12);
    cyc();
    in_valid = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL mid_pending got=%0h exp=1", wr_en); end
    reset = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || count !== 7'd0 || in_ready !== 1'b0) begin failures++; $display("FAIL mid_reset got=%0h/%0d/%0h exp=0/0/0", wr_en, count, in_ready); end
    cyc();
    reset = 1'b1;
    repeat (3) cyc();
    wr_ready = 1'b1;
    r = ref_enc(0, 7, 9, -1);
    req(0, 7, 9, -1);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%0h exp=1", in_ready); end
    cyc();
    in_valid = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== r[31:0]) begin failures++; $display("FAIL mid_first got=%0h@%0h:%08h exp=1@0:%08h", wr_en, wr_addr, wr_data, r[31:0]); end
    cyc();
    checks++; if (count !== 7'd1) begin failures++; $display("FAIL mid_count got=%0d exp=1", count); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ldur();
    test_back_to_back();
    test_errors();
    test_backpressure();
    test_full();
    test_random_stream();
    test_random_errors();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
